// File: rtl/coef_mem_arbiter.sv
// Round-robin arbiter sharing the FIR coefficient memory s2 read port.
// Define COEF_MEM_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority.
module coef_mem_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 15,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic [AW-1:0]      mem_address,
  output logic               mem_clken,
  input  logic [DW-1:0]      mem_readdata,
  output logic               mem_clk
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0] sel;
  logic          any;
  logic          issue;
  logic [RD_LAT:0] tag_v;
  logic [IW-1:0]   tag_i [RD_LAT+1];

`ifndef COEF_MEM_ARBITER_FIXED_PRIO_EN
  logic [IW-1:0] ptr;
`endif

  always_comb begin
    int j;
    j   = 0;
    sel = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef COEF_MEM_ARBITER_FIXED_PRIO_EN
      j = k;
`else
      // rotate the search so it starts at ptr
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
`endif
      if (!any && req[j]) begin
        any = 1'b1;
        sel = IW'(j);
      end
    end
  end

  assign issue     = any & ~hold;
  assign mem_clken = |tag_v;
  assign busy      = (|tag_v) | (|gnt);
  assign mem_clk   = clk;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt         <= '0;
      mem_address <= '0;
      tag_v       <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      for (int k = 0; k <= RD_LAT; k++)
        tag_i[k] <= '0;
`ifndef COEF_MEM_ARBITER_FIXED_PRIO_EN
      ptr         <= '0;
`endif
    end else begin
      gnt <= issue ? (NREQ'(1) << sel) : '0;
      if (issue) begin
        mem_address <= req_addr[int'(sel)*AW +: AW];
`ifndef COEF_MEM_ARBITER_FIXED_PRIO_EN
        ptr <= (sel == IW'(NREQ-1)) ? '0 : sel + 1'b1;
`endif
      end
      // tag stage k tracks the read whose address went out k cycles ago
      tag_v    <= {tag_v[RD_LAT-1:0], issue};
      tag_i[0] <= sel;
      for (int k = 1; k <= RD_LAT; k++)
        tag_i[k] <= tag_i[k-1];
      rvalid <= tag_v[RD_LAT] ? (NREQ'(1) << tag_i[RD_LAT]) : '0;
      if (tag_v[RD_LAT])
        rdata <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_coef_mem_arbiter.sv
// Directed self-checking bench for coef_mem_arbiter.
// Memory model returns address + 0x1000 after two clken cycles.
module tb_coef_mem_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 15;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               hold;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic               busy;
  logic [AW-1:0]      mem_address;
  logic               mem_clken;
  logic [DW-1:0]      mem_readdata;
  logic               mem_clk;

  logic [AW-1:0] p1, p2;
  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  g_tab [9];
  logic [3:0]  v_tab [9];
  logic [31:0] d_tab [9];

  always #5 clk = ~clk;

  coef_mem_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hold(hold),
    .req(req),
    .req_addr(req_addr),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .busy(busy),
    .mem_address(mem_address),
    .mem_clken(mem_clken),
    .mem_readdata(mem_readdata),
    .mem_clk(mem_clk)
  );

  always @(posedge clk) begin
    if (mem_clken) begin
      p1 <= mem_address;
      p2 <= p1;
    end
  end
  assign mem_readdata = 32'(p2) + 32'h1000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; req = '0; req_addr = '0;
    p1 = '0; p2 = '0;
    repeat (3) step();
    n_cmp++;
    if ({gnt, rvalid, rdata, busy, mem_address, mem_clken} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h busy=%b addr=%h ce=%b want all 0",
               gnt, rvalid, rdata, busy, mem_address, mem_clken);
    end
    n_cmp++;
    if (mem_clk !== 1'b1) begin
      n_bad++;
      $display("FAIL mem_clk: got %b want 1", mem_clk);
    end
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = AW'(16'h0200 + i);
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({gnt, rvalid, rdata, busy, mem_address, mem_clken} !== '0) begin
      n_bad++;
      $display("FAIL reset_midflight: got gnt=%b rv=%b rd=%h busy=%b addr=%h ce=%b want all 0",
               gnt, rvalid, rdata, busy, mem_address, mem_clken);
    end
    rst = 1'b0;
    req = '0;
    for (int s = 0; s < 4; s++) begin
      step();
      n_cmp++;
      if (rvalid !== 4'b0000 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_rvalid step %0d: got rv=%b busy=%b want 0000 0", s, rvalid, busy);
      end
    end
  endtask

  task automatic test_single();
    req = 4'b0001;
    req_addr[0 +: AW] = 15'h0010;
    step();
    n_cmp++;
    if (gnt !== 4'b0001 || mem_address !== 15'h0010) begin
      n_bad++;
      $display("FAIL single_gnt: got gnt=%b addr=%h want 0001 0010", gnt, mem_address);
    end
    req = '0;
    for (int s = 2; s <= 3; s++) begin
      step();
      n_cmp++;
      if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin
        n_bad++;
        $display("FAIL single_early step %0d: got rv=%b gnt=%b want 0000 0000", s, rvalid, gnt);
      end
    end
    step();
    n_cmp++;
    if (rvalid !== 4'b0001 || rdata !== 32'h0000_1010) begin
      n_bad++;
      $display("FAIL single_rvalid: got rv=%b rd=%h want 0001 00001010", rvalid, rdata);
    end
    step();
    n_cmp++;
    if (rvalid !== 4'b0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_after: got rv=%b busy=%b want 0000 0", rvalid, busy);
    end
  endtask

  task automatic test_rr();
    do_reset();
    g_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
              4'b0000, 4'b0000, 4'b0000, 4'b0000};
    v_tab = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
              4'b0100, 4'b1000, 4'b0001, 4'b0000};
    d_tab = '{32'h0, 32'h0, 32'h0, 32'h1100, 32'h1101,
              32'h1102, 32'h1103, 32'h1100, 32'h0};
    req = 4'b1111;
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = AW'(16'h0100 + i);
    for (int s = 0; s < 9; s++) begin
      step();
      if (s == 4) req = '0;
      n_cmp++;
      if (gnt !== g_tab[s]) begin
        n_bad++;
        $display("FAIL rr_gnt step %0d: got %b want %b", s, gnt, g_tab[s]);
      end
      n_cmp++;
      if (rvalid !== v_tab[s]) begin
        n_bad++;
        $display("FAIL rr_rvalid step %0d: got %b want %b", s, rvalid, v_tab[s]);
      end
      if (v_tab[s] != 4'b0000) begin
        n_cmp++;
        if (rdata !== d_tab[s]) begin
          n_bad++;
          $display("FAIL rr_rdata step %0d: got %h want %h", s, rdata, d_tab[s]);
        end
      end
    end
  endtask

  task automatic test_fixed();
    do_reset();
    req = 4'b0110;
    req_addr[1*AW +: AW] = 15'h0031;
    req_addr[2*AW +: AW] = 15'h0032;
    for (int s = 0; s < 6; s++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0010) begin
        n_bad++;
        $display("FAIL fixed_gnt step %0d: got %b want 0010", s, gnt);
      end
      if (s >= 3) begin
        n_cmp++;
        if (rvalid !== 4'b0010 || rdata !== 32'h1031) begin
          n_bad++;
          $display("FAIL fixed_rvalid step %0d: got %b %h want 0010 00001031", s, rvalid, rdata);
        end
      end
    end
    req = '0;
    repeat (4) step();
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0101;
    req_addr[0*AW +: AW] = 15'h0020;
    req_addr[2*AW +: AW] = 15'h0022;
    step();
    hold = 1'b1;
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_bad++;
      $display("FAIL hold_first_gnt: got %b want 0001", gnt);
    end
    for (int s = 2; s <= 6; s++) begin
      step();
      n_cmp++;
      if (gnt !== 4'b0000) begin
        n_bad++;
        $display("FAIL hold_no_gnt step %0d: got %b want 0000", s, gnt);
      end
      n_cmp++;
      if (rvalid !== ((s == 4) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL hold_rvalid step %0d: got %b want %b", s, rvalid,
                 (s == 4) ? 4'b0001 : 4'b0000);
      end
      if (s == 3) begin
        n_cmp++;
        if (busy !== 1'b1 || mem_clken !== 1'b1) begin
          n_bad++;
          $display("FAIL hold_busy_inflight: got busy=%b ce=%b want 1 1", busy, mem_clken);
        end
      end
      if (s == 4) begin
        n_cmp++;
        if (rdata !== 32'h1020) begin
          n_bad++;
          $display("FAIL hold_rdata: got %h want 00001020", rdata);
        end
      end
      if (s >= 4) begin
        n_cmp++;
        if (busy !== 1'b0 || mem_clken !== 1'b0) begin
          n_bad++;
          $display("FAIL hold_idle step %0d: got busy=%b ce=%b want 0 0", s, busy, mem_clken);
        end
      end
    end
    hold = 1'b0;
    req  = '0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    a = 15'h0040;
    req = 4'b0001;
    req_addr[0 +: AW] = a;
    for (int s = 1; s <= 12; s++) begin
      step();
      n_cmp++;
      if (gnt !== ((s <= 8) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL b2b_gnt step %0d: got %b", s, gnt);
      end
      if (gnt[0]) begin
        a = a + 1'b1;
        req_addr[0 +: AW] = a;
      end
      if (s == 8) req = '0;
      n_cmp++;
      if (mem_clken !== (s <= 10)) begin
        n_bad++;
        $display("FAIL b2b_clken step %0d: got %b want %b", s, mem_clken, s <= 10);
      end
      n_cmp++;
      if (rvalid !== ((s >= 4 && s <= 11) ? 4'b0001 : 4'b0000)) begin
        n_bad++;
        $display("FAIL b2b_rvalid step %0d: got %b", s, rvalid);
      end
      if (s >= 4 && s <= 11) begin
        n_cmp++;
        if (rdata !== 32'h1040 + 32'(s - 4)) begin
          n_bad++;
          $display("FAIL b2b_rdata step %0d: got %h want %h", s, rdata, 32'h1040 + 32'(s - 4));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
`ifdef COEF_MEM_ARBITER_FIXED_PRIO_EN
    test_fixed();
`else
    test_rr();
`endif
    test_hold();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
